// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the 20x20 framebuffer port arbiter.
//   - Framebuffer geometry (FB_COLS, FB_ROWS, FB_WORDS).
//   - Pixel format: RGB 2:2:2 packed into bits [5:0] of each 8-bit word.
//   - Port FSM state enum used by fb_port_arbiter.
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_COLS  = 20;
  localparam int FB_ROWS  = 20;
  localparam int FB_WORDS = FB_COLS * FB_ROWS;

  // RGB 2:2:2 pixel layout: {r[1:0], g[1:0], b[1:0]} in bits [5:0]
  localparam int PIX_BITS  = 6;
  localparam int PIX_CH_W  = 2;
  localparam int PIX_R_LSB = 4;
  localparam int PIX_G_LSB = 2;
  localparam int PIX_B_LSB = 0;

  // One state per RAM port cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } port_state_e;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter_if
// Bundles the scan-out read path, the pixel-write handshake and the RAM port
// of fb_port_arbiter. Signal prefixes (i_/o_) are from the arbiter's view.
//   slave  : arbiter side
//   master : environment side (display path, write source, RAM)
// ---------------------------------------------------------------------------
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  // scan-out read path
  logic              i_rd_en;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_valid;
  // pixel write handshake
  logic              i_wr_valid;
  logic              o_wr_ready;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [DATA_W-1:0] i_wr_data;
  // RAM port
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_we;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_rd_en, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
    output o_rd_data, o_rd_valid, o_wr_ready, o_mem_addr, o_mem_we, o_mem_wdata
  );

  modport master (
    output i_rd_en, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
    input  o_rd_data, o_rd_valid, o_wr_ready, o_mem_addr, o_mem_we, o_mem_wdata
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// ---------------------------------------------------------------------------
// fb_wr_fifo
// Small synchronous FIFO buffering pending pixel writes.
// Ports:
//   clk, srst        : clock, synchronous active-high reset (flushes FIFO)
//   i_push, i_wdata  : enqueue (ignored when full)
//   i_pop            : dequeue head (ignored when empty)
//   o_rdata          : current head entry (combinational view of storage)
//   o_full, o_empty  : occupancy flags, derived from registered count only
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign o_full  = (cnt_q == FULL_CNT);
  assign o_empty = (cnt_q == '0);
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;
  assign o_rdata = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_q == AW'(gi))) mem_q[gi] <= i_wdata;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter
// Shares the single-port framebuffer RAM between scan-out reads (absolute
// priority) and buffered pixel writes, which commit only in read-free cycles.
// Ports:
//   i_pixel_clk : clock, all registers on its rising edge
//   i_reset     : synchronous active-high reset
//   i_hvesync   : {de, vsync, hsync}; only vsync is used, and only with the
//                 optional vblank write window
//   bus         : fb_port_arbiter_if.slave (read path, write handshake, RAM)
//   o_wr_err    : sticky, an out-of-range write was dropped
//   o_wr_count  : committed-write counter, wraps 0xFFFF -> 0
// Optional feature: define FB_VBLANK_WRITE_EN to restrict commits to cycles
// where vsync equals VSYNC_POL (tear-free updates). Default: window open.
// Read latency: request edge N -> o_rd_valid registered at N+2+MEM_LAT.
// ---------------------------------------------------------------------------
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int FB_WORDS   = fb_pkg::FB_WORDS,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_LAT    = 1
`ifdef FB_VBLANK_WRITE_EN
  , parameter logic VSYNC_POL = 1'b0
`endif
) (
  input  logic                i_pixel_clk,
  input  logic                i_reset,
  input  logic [2:0]          i_hvesync,
  fb_port_arbiter_if.slave    bus,
  output logic                o_wr_err,
  output logic [15:0]         o_wr_count
);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(FB_WORDS);

  port_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ENT_W-1:0]  wr_ent_q, wr_ent_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MEM_LAT:0]  lat_q, lat_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_err_q, wr_err_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic              wr_window;
  logic              wr_fire, addr_ok;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]  fifo_head;
  logic              unused_hvesync;

  // de and hsync are never needed; vsync only with the vblank window.
  assign unused_hvesync = ^i_hvesync;

`ifdef FB_VBLANK_WRITE_EN
  assign wr_window = (i_hvesync[1] == VSYNC_POL);
`else
  assign wr_window = 1'b1;
`endif

  // Ready comes from registered occupancy only; a full FIFO stays not-ready
  // even while popping.
  assign bus.o_wr_ready = ~fifo_full;
  assign wr_fire        = bus.i_wr_valid & ~fifo_full;
  assign addr_ok        = ({1'b0, bus.i_wr_addr} < ADDR_LIMIT);
  assign fifo_push      = wr_fire & addr_ok;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_wr_fifo (
    .clk     (i_pixel_clk),
    .srst    (i_reset),
    .i_push  (fifo_push),
    .i_wdata ({bus.i_wr_addr, bus.i_wr_data}),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d     = ST_IDLE;
    rd_addr_d   = rd_addr_q;
    wr_ent_d    = wr_ent_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;

    if (bus.i_rd_en)                   state_d = ST_RD;
    else if (!fifo_empty && wr_window) state_d = ST_WR;

    // The head leaves the FIFO on the edge that enters ST_WR and is held in
    // wr_ent_q; the RAM port is driven from it one edge later.
    fifo_pop = (state_d == ST_WR);
    if (state_d == ST_RD) rd_addr_d = bus.i_rd_addr;
    if (fifo_pop)         wr_ent_d  = fifo_head;

    case (state_q)
      ST_RD: mem_addr_d = rd_addr_q;
      ST_WR: begin
        mem_addr_d  = wr_ent_q[ENT_W-1:DATA_W];
        mem_wdata_d = wr_ent_q[DATA_W-1:0];
        mem_we_d    = 1'b1;
      end
      default: ;
    endcase

    // lat_q[0] rises with the read address on the RAM port; lat_q[MEM_LAT]
    // marks the cycle in which i_mem_rdata belongs to that read.
    lat_d      = {lat_q[MEM_LAT-1:0], (state_q == ST_RD)};
    rd_valid_d = lat_q[MEM_LAT];
    if (lat_q[MEM_LAT]) rd_data_d = bus.i_mem_rdata;

    wr_err_d   = wr_err_q | (wr_fire & ~addr_ok);
    wr_count_d = wr_count_q + 16'(mem_we_q);
  end

  always_ff @(posedge i_pixel_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      wr_ent_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      lat_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      wr_ent_q    <= wr_ent_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      lat_q       <= lat_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_err_q    <= wr_err_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_rd_data   = rd_data_q;
  assign bus.o_rd_valid  = rd_valid_q;
  assign o_wr_err        = wr_err_q;
  assign o_wr_count      = wr_count_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_port_arbiter
// Directed bench for fb_port_arbiter with a 1-cycle-latency RAM model.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_fb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hvesync;
  logic        wr_err;
  logic [15:0] wr_count;

  fb_port_arbiter_if #(.ADDR_W(9), .DATA_W(8)) bus ();

  fb_port_arbiter #(
    .ADDR_W(9), .DATA_W(8), .FB_WORDS(400), .FIFO_DEPTH(4), .MEM_LAT(1)
  ) dut (
    .i_pixel_clk (clk),
    .i_reset     (rst),
    .i_hvesync   (hvesync),
    .bus         (bus),
    .o_wr_err    (wr_err),
    .o_wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read (1 cycle latency)
  logic [7:0] ram [0:511];
  logic       pre_we;
  logic [8:0] pre_addr;
  logic [7:0] pre_data;
  logic [7:0] mem_rdata_q;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
    mem_rdata_q <= ram[bus.o_mem_addr];
  end
  assign bus.i_mem_rdata = mem_rdata_q;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one read and check the result three edges after the request edge.
  task automatic rd_check(input logic [8:0] addr, input logic [7:0] exp);
    bus.i_rd_en = 1'b1;
    bus.i_rd_addr = addr;
    tick;
    bus.i_rd_en = 1'b0;
    tick;
    tick;
    tick;
    $display("rd addr=%0d data=%0h valid=%0b", addr, bus.o_rd_data, bus.o_rd_valid);
    chk("rdc_valid", 32'(bus.o_rd_valid), 32'd1);
    chk("rdc_data", 32'(bus.o_rd_data), 32'(exp));
  endtask

  function automatic logic [8:0] t4_addr(input int idx);
    case (idx % 4)
      0: return 9'd5;
      1: return 9'd399;
      2: return 9'd10;
      default: return 9'd11;
    endcase
  endfunction

  function automatic logic [7:0] t4_data(input int idx);
    case (idx % 4)
      0: return 8'h2A;
      1: return 8'h3C;
      2: return 8'h10;
      default: return 8'h11;
    endcase
  endfunction

  logic       req_hist [0:39];
  logic [7:0] exp_hist [0:39];
  int         k;
  logic       xfer;

  initial begin
    rst = 1'b1;
    hvesync = 3'b000;
    bus.i_rd_en = 1'b0;
    bus.i_rd_addr = '0;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
    pre_we = 1'b1;
    pre_addr = 9'd5;
    pre_data = 8'h2A;
    tick;
    pre_we = 1'b0;
    tick;
    tick;

    // ---- reset values
    chk("rst_mem_we",   32'(bus.o_mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
    chk("rst_mem_wdata",32'(bus.o_mem_wdata), 32'd0);
    chk("rst_rd_valid", 32'(bus.o_rd_valid), 32'd0);
    chk("rst_rd_data",  32'(bus.o_rd_data), 32'd0);
    chk("rst_wr_err",   32'(wr_err), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_wr_ready", 32'(bus.o_wr_ready), 32'd1);
    rst = 1'b0;

    // ---- T1: read latency 3 cycles
    bus.i_rd_en = 1'b1;
    bus.i_rd_addr = 9'd5;
    tick;
    bus.i_rd_en = 1'b0;
    chk("t1_valid_n1", 32'(bus.o_rd_valid), 32'd0);
    tick;
    chk("t1_mem_addr", 32'(bus.o_mem_addr), 32'd5);
    chk("t1_mem_we",   32'(bus.o_mem_we), 32'd0);
    chk("t1_valid_n2", 32'(bus.o_rd_valid), 32'd0);
    tick;
    chk("t1_valid_n3m", 32'(bus.o_rd_valid), 32'd0);
    tick;
    $display("rd addr=5 data=%0h valid=%0b", bus.o_rd_data, bus.o_rd_valid);
    chk("t1_valid", 32'(bus.o_rd_valid), 32'd1);
    chk("t1_data",  32'(bus.o_rd_data), 32'h2A);
    tick;
    chk("t1_valid_off", 32'(bus.o_rd_valid), 32'd0);

    // ---- T2: reads starve writes, FIFO fills, then drains back to back
    bus.i_rd_en = 1'b1;
    bus.i_rd_addr = 9'd5;
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_addr = 9'(10 + i);
      bus.i_wr_data = 8'(16 + i);
      chk($sformatf("t2_ready%0d", i), 32'(bus.o_wr_ready), (i < 4) ? 32'd1 : 32'd0);
      tick;
      chk("t2_no_we", 32'(bus.o_mem_we), 32'd0);
    end
    bus.i_wr_valid = 1'b0;
    tick;
    chk("t2_ready_full", 32'(bus.o_wr_ready), 32'd0);
    chk("t2_no_we_hold", 32'(bus.o_mem_we), 32'd0);
    bus.i_rd_en = 1'b0;
    tick;
    chk("t2_we_e1", 32'(bus.o_mem_we), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick;
      $display("wr commit addr=%0d data=%0h we=%0b", bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_we);
      chk($sformatf("t2_we%0d", i),    32'(bus.o_mem_we), 32'd1);
      chk($sformatf("t2_addr%0d", i),  32'(bus.o_mem_addr), 32'(10 + i));
      chk($sformatf("t2_wdata%0d", i), 32'(bus.o_mem_wdata), 32'(16 + i));
    end
    tick;
    chk("t2_we_end", 32'(bus.o_mem_we), 32'd0);
    chk("t2_count",  32'(wr_count), 32'd4);
    chk("t2_ready_end", 32'(bus.o_wr_ready), 32'd1);

    // ---- T3: out-of-range write dropped, sticky error
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr = 9'd400;
    bus.i_wr_data = 8'hFF;
    chk("t3_ready400", 32'(bus.o_wr_ready), 32'd1);
    tick;
    bus.i_wr_valid = 1'b0;
    chk("t3_err", 32'(wr_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t3_no_we", 32'(bus.o_mem_we), 32'd0);
    end
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr = 9'd399;
    bus.i_wr_data = 8'h3C;
    tick;
    bus.i_wr_valid = 1'b0;
    chk("t3_we_e1", 32'(bus.o_mem_we), 32'd0);
    tick;
    chk("t3_we_e2", 32'(bus.o_mem_we), 32'd0);
    tick;
    $display("wr commit addr=%0d data=%0h we=%0b", bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_we);
    chk("t3_we_e3",  32'(bus.o_mem_we), 32'd1);
    chk("t3_addr",   32'(bus.o_mem_addr), 32'd399);
    chk("t3_wdata",  32'(bus.o_mem_wdata), 32'h3C);
    tick;
    chk("t3_count",  32'(wr_count), 32'd5);
    chk("t3_err_sticky", 32'(wr_err), 32'd1);
    rd_check(9'd399, 8'h3C);

    // ---- T4: alternating reads with a steady write stream
    k = 0;
    for (int t = 0; t < 30; t++) begin
      req_hist[t] = (t < 16) && (t % 2 == 0);
      exp_hist[t] = t4_data(t / 2);
      bus.i_rd_en = req_hist[t];
      bus.i_rd_addr = t4_addr(t / 2);
      bus.i_wr_valid = (k < 8);
      bus.i_wr_addr = 9'(100 + k);
      bus.i_wr_data = 8'(k);
      xfer = bus.i_wr_valid && bus.o_wr_ready;
      tick;
      if (xfer) k++;
      if (t >= 1 && req_hist[t-1])
        chk("t4_we_vs_rd", 32'(bus.o_mem_we), 32'd0);
      if (t >= 3) begin
        chk("t4_rvalid", 32'(bus.o_rd_valid), 32'(req_hist[t-3]));
        if (req_hist[t-3]) begin
          $display("rd t=%0d data=%0h", t - 3, bus.o_rd_data);
          chk("t4_rdata", 32'(bus.o_rd_data), 32'(exp_hist[t-3]));
        end
      end
    end
    bus.i_rd_en = 1'b0;
    bus.i_wr_valid = 1'b0;
    tick;
    tick;
    chk("t4_accepted", 32'(k), 32'd8);
    chk("t4_count", 32'(wr_count), 32'd13);
    rd_check(9'd100, 8'h00);
    rd_check(9'd107, 8'h07);

    // ---- T5: write window vs vsync (vsync inactive level = 1)
    hvesync = 3'b010;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr = 9'd200;
    bus.i_wr_data = 8'h55;
    tick;
    bus.i_wr_valid = 1'b0;
`ifdef FB_VBLANK_WRITE_EN
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t5_stall", 32'(bus.o_mem_we), 32'd0);
    end
    hvesync = 3'b000;
    tick;
    chk("t5_we_pop", 32'(bus.o_mem_we), 32'd0);
    tick;
`else
    tick;
    chk("t5_we_pop", 32'(bus.o_mem_we), 32'd0);
    tick;
`endif
    $display("wr commit addr=%0d data=%0h we=%0b", bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_we);
    chk("t5_we",    32'(bus.o_mem_we), 32'd1);
    chk("t5_addr",  32'(bus.o_mem_addr), 32'd200);
    chk("t5_wdata", 32'(bus.o_mem_wdata), 32'h55);
    hvesync = 3'b000;
    tick;
    chk("t5_count", 32'(wr_count), 32'd14);

    // ---- T6: reset with writes queued and a read in flight
    bus.i_rd_en = 1'b1;
    bus.i_rd_addr = 9'd5;
    for (int i = 0; i < 3; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_addr = 9'(300 + i);
      bus.i_wr_data = 8'(i + 1);
      tick;
    end
    bus.i_wr_valid = 1'b0;
    tick;
    chk("t6_pre_ready", 32'(bus.o_wr_ready), 32'd1);
    rst = 1'b1;
    bus.i_rd_en = 1'b0;
    tick;
    rst = 1'b0;
    chk("t6_we",    32'(bus.o_mem_we), 32'd0);
    chk("t6_valid", 32'(bus.o_rd_valid), 32'd0);
    chk("t6_ready", 32'(bus.o_wr_ready), 32'd1);
    chk("t6_count", 32'(wr_count), 32'd0);
    chk("t6_err",   32'(wr_err), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("t6_we_after",    32'(bus.o_mem_we), 32'd0);
      chk("t6_valid_after", 32'(bus.o_rd_valid), 32'd0);
    end
    chk("t6_count_after", 32'(wr_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
